puf_eval_ctrl: RTL and testbench

PUF_EVAL_CTRL -- requirements
Module: puf_eval_ctrl

---
 rtl/puf_ctrl_pkg.sv | 16 +
 rtl/puf_bit_vote.sv | 49 ++++
 rtl/puf_eval_ctrl.sv | 110 +++++++++++
 tb/tb_puf_eval_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_ctrl_pkg.sv
// PUF evaluation controller: shared state
// encoding and default timing parameters.
package puf_ctrl_pkg;

  localparam int SETTLE_CYCLES_DEF = 8;
  localparam int NUM_SAMPLES_DEF   = 5;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SETTLE,
    SAMPLE,
    RESP
  } state_t;

endpackage

// File: rtl/puf_bit_vote.sv
// One response bit: counts ones over the
// sample window and registers the verdict.
module puf_bit_vote
  import puf_ctrl_pkg::*;
#(
  parameter int NUM_SAMPLES = NUM_SAMPLES_DEF,
  parameter int CW = $clog2(NUM_SAMPLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic smp_en,
  input  logic bit_in,
  input  logic dec_en,
  output logic vote,
  output logic unstable
);

  localparam logic [CW-1:0] N = CW'(NUM_SAMPLES);
  localparam logic [CW-1:0] HALF =
    CW'(NUM_SAMPLES / 2);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;

  // The verdict uses cnt_nx so the last sample
  // counts on the same edge the result is taken.
  always_comb begin
    cnt_nx = cnt;
    if (smp_en && bit_in && cnt != N)
      cnt_nx = cnt + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      vote     <= 1'b0;
      unstable <= 1'b0;
    end else begin
      if (clr) cnt <= '0;
      else     cnt <= cnt_nx;
      if (dec_en) begin
        vote     <= cnt_nx > HALF;
        unstable <= cnt_nx != '0 && cnt_nx != N;
      end
    end
  end

endmodule

// File: rtl/puf_eval_ctrl.sv
// PUF evaluation controller: clear, settle,
// sample N times, majority-vote, respond.
module puf_eval_ctrl
  import puf_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int NUM_SAMPLES = NUM_SAMPLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              abort,
  output logic              puf_reset,
  output logic              puf_start,
  output logic [ADDR_W-1:0] puf_addr,
  input  logic [DATA_W-1:0] puf_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [DATA_W-1:0] rsp_unstable,
  output logic              busy
);

  localparam int CW = $clog2(NUM_SAMPLES + 1);
  localparam logic [7:0] SET_LAST =
    8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] SMP_LAST =
    8'(NUM_SAMPLES - 1);

  state_t     state;
  state_t     state_nx;
  logic [7:0] cnt;
  logic       accept;
  logic       hs;
  logic       last_settle;
  logic       last_sample;

  assign accept = state == IDLE && req_valid;
  assign hs     = rsp_valid && rsp_ready;
  assign last_settle =
    state == SETTLE && cnt == SET_LAST;
  assign last_sample =
    state == SAMPLE && cnt == SMP_LAST;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort && state != IDLE) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (req_valid) state_nx = CLR;
        CLR:     state_nx = SETTLE;
        SETTLE:  if (last_settle) state_nx = SAMPLE;
        SAMPLE:  if (last_sample) state_nx = RESP;
        RESP:    if (hs) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready = state == IDLE;
    busy      = state != IDLE;
    puf_start = state == SETTLE
             || state == SAMPLE;
    puf_reset = reset || state == CLR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      puf_addr  <= '0;
      rsp_valid <= 1'b0;
    end else begin
      if (state != state_nx) cnt <= '0;
      else if (puf_start)    cnt <= cnt + 8'd1;
      if (accept) puf_addr <= req_addr;
      // Verdict lands on RESP entry; valid
      // follows one edge later from its flop.
      rsp_valid <= state == RESP
                && state_nx == RESP;
    end
  end

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    puf_bit_vote #(
      .NUM_SAMPLES(NUM_SAMPLES),
      .CW(CW)
    ) u_vote (
      .clk(clk),
      .reset(reset),
      .clr(accept),
      .smp_en(state == SAMPLE),
      .bit_in(puf_out[i]),
      .dec_en(last_sample && !abort),
      .vote(rsp_data[i]),
      .unstable(rsp_unstable[i])
    );
  end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Random + directed bench for puf_eval_ctrl
// against a timeline-based reference model.
module tb_puf_eval_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int S  = 8;
  localparam int N  = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic          abort = 1'b0;
  logic [DW-1:0] puf_out = '0;
  logic          rsp_ready = 1'b1;
  logic          req_ready;
  logic          puf_reset;
  logic          puf_start;
  logic [AW-1:0] puf_addr;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [DW-1:0] rsp_unstable;
  logic          busy;

  puf_eval_ctrl #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .SETTLE_CYCLES(S),
    .NUM_SAMPLES(N)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_addr(req_addr),
    .req_ready(req_ready),
    .abort(abort),
    .puf_reset(puf_reset),
    .puf_start(puf_start),
    .puf_addr(puf_addr),
    .puf_out(puf_out),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_unstable(rsp_unstable),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h t=%0t",
                  nm, act, exp, $time);
  endtask

  // Model: m_t = edges since acceptance.
  // 0 clear, 1..S settle, S+1..S+N sample,
  // samples land on edges S+2..S+N+1,
  // valid shows from edge S+N+2.
  bit            m_busy = 1'b0;
  bit            m_valid = 1'b0;
  int            m_t = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [DW-1:0] m_unst = '0;
  int            m_ones [DW];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_valid = 0; m_t = 0;
      m_addr = '0; m_data = '0; m_unst = '0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy = 1; m_t = 0; m_addr = req_addr;
        foreach (m_ones[i]) m_ones[i] = 0;
      end
    end else if (abort || (m_valid && rsp_ready)) begin
      m_busy = 0; m_valid = 0;
    end else begin
      m_t++;
      if (m_t >= S + 2 && m_t <= S + N + 1)
        foreach (m_ones[i])
          m_ones[i] += int'(puf_out[i]);
      if (m_t == S + N + 1)
        foreach (m_ones[i]) begin
          m_data[i] = m_ones[i] > N / 2;
          m_unst[i] = m_ones[i] != 0
                   && m_ones[i] != N;
        end
      if (m_t == S + N + 2) m_valid = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(!m_busy));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("puf_reset", 32'(puf_reset),
          32'(reset || (m_busy && m_t == 0)));
      chk("puf_start", 32'(puf_start),
          32'(m_busy && m_t >= 1 && m_t <= S + N));
      chk("puf_addr", 32'(puf_addr), 32'(m_addr));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      chk("rsp_data", 32'(rsp_data), 32'(m_data));
      chk("rsp_unstable", 32'(rsp_unstable),
          32'(m_unst));
    end
  end

  task automatic accept(input logic [AW-1:0] a,
                        output int t);
    int k;
    k = 0;
    while (!req_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    chk("idle_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr = a;
    @(posedge clk); #1;
    t = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(input int t0,
                            output int lat);
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (rsp_valid) begin
        lat = cyc - t0;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  logic [DW-1:0] seq [N];
  logic [DW-1:0] base;
  int t;
  int lat;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    seq = '{8'h01, 8'h01, 8'h00, 8'h01, 8'h00};
    @(posedge clk); #1;
    chk_en = 1'b1;
    chk("rst_puf_reset", 32'(puf_reset), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'(puf_addr), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // stable response
    puf_out = 8'hA5;
    accept(4'd3, t);
    wait_valid(t, lat);
    chk("lat_stable", 32'(lat), 32'd15);
    chk("data_stable", 32'(rsp_data), 32'hA5);
    chk("unst_stable", 32'(rsp_unstable), 32'h00);
    chk("addr_stable", 32'(puf_addr), 32'd3);
    @(posedge clk); #1;

    // majority vote
    puf_out = '0;
    accept(4'd5, t);
    repeat (1 + S) @(posedge clk);
    for (int j = 0; j < N; j++) begin
      #1 puf_out = seq[j];
      @(posedge clk);
    end
    #1 puf_out = 8'hFF;
    @(posedge clk); #1;
    chk("vote_valid", 32'(rsp_valid), 32'd1);
    chk("vote_data", 32'(rsp_data), 32'h01);
    chk("vote_unst", 32'(rsp_unstable), 32'h01);
    @(posedge clk); #1;

    // backpressure
    puf_out = 8'h3C;
    rsp_ready = 1'b0;
    accept(4'd2, t);
    wait_valid(t, lat);
    chk("lat_bp", 32'(lat), 32'd15);
    puf_out = 8'hFF;
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", 32'(rsp_data), 32'h3C);
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle", 32'(busy), 32'd0);
    chk("bp_req_ready", 32'(req_ready), 32'd1);
    chk("bp_drop", 32'(rsp_valid), 32'd0);

    // abort in settle cycle 4
    puf_out = 8'h5A;
    accept(4'd7, t);
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(rsp_valid), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    accept(4'd9, t);
    wait_valid(t, lat);
    chk("lat_after_abort", 32'(lat), 32'd15);
    chk("data_after_abort", 32'(rsp_data), 32'h5A);
    @(posedge clk); #1;

    // reset during sample
    accept(4'd4, t);
    repeat (S + 3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("arst_valid", 32'(rsp_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_start", 32'(puf_start), 32'd0);
    chk("arst_puf_reset", 32'(puf_reset), 32'd1);
    chk("arst_addr", 32'(puf_addr), 32'd0);
    chk("arst_data", 32'(rsp_data), 32'd0);
    chk("arst_unst", 32'(rsp_unstable), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      chk("arst_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // abort and rsp_ready together in RESP
    rsp_ready = 1'b0;
    accept(4'd1, t);
    wait_valid(t, lat);
    chk("lat_simul", 32'(lat), 32'd15);
    abort = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("simul_valid", 32'(rsp_valid), 32'd0);
    chk("simul_busy", 32'(busy), 32'd0);

    // randomized traffic
    base = DW'($urandom);
    repeat (600) begin
      @(posedge clk); #1;
      req_valid = $urandom_range(0, 3) == 0;
      req_addr = AW'($urandom);
      if ($urandom_range(0, 2) != 0)
        puf_out = base;
      else
        puf_out = DW'($urandom);
      if ($urandom_range(0, 50) == 0)
        base = DW'($urandom);
      rsp_ready = $urandom_range(0, 2) != 0;
      abort = $urandom_range(0, 60) == 0;
    end
    #1;
    req_valid = 1'b0;
    abort = 1'b0;
    rsp_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
